// File: rtl/ripple_count_seq.sv
// Sequencer for an asynchronous ripple counter: clear, pulse, settle, sample until target or stop.
// Defining RCS_SHADOW_CHECK_EN adds a shadow count that flags missed or extra counter edges.

module ripple_count_seq #(
  parameter int W      = 16,
  parameter int SETTLE = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         stop,
  input  logic [W-1:0] target,
  input  logic [W-1:0] cnt_q,
  output logic         cnt_pulse,
  output logic         cnt_clr,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] value,
  output logic         stopped,
  output logic         err
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SETTLE,
    S_CHECK,
    S_PULSE,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  target_q, target_d;
  logic [W-1:0]  value_q, value_d;
  logic [SW-1:0] settle_q, settle_d;
  logic          stop_lat_q, stop_lat_d;
  logic          stopped_q, stopped_d;
  logic          pulse_q, pulse_d;
  logic          clr_q, clr_d;
`ifdef RCS_SHADOW_CHECK_EN
  logic [W-1:0]  shadow_q, shadow_d;
  logic          err_q, err_d;
`endif

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    target_d   = target_q;
    value_d    = value_q;
    settle_d   = settle_q;
    stop_lat_d = stop_lat_q;
    stopped_d  = stopped_q;
`ifdef RCS_SHADOW_CHECK_EN
    shadow_d   = shadow_q;
    err_d      = err_q;
`endif

    if (state_q != S_IDLE && stop) stop_lat_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          target_d   = target;
          stop_lat_d = stop;
          stopped_d  = 1'b0;
`ifdef RCS_SHADOW_CHECK_EN
          err_d      = 1'b0;
`endif
          state_d    = S_CLEAR;
        end
      end
      S_CLEAR: begin
        settle_d = SW'(SETTLE - 1);
`ifdef RCS_SHADOW_CHECK_EN
        shadow_d = '0;
`endif
        state_d  = S_SETTLE;
      end
      S_PULSE: begin
        settle_d = SW'(SETTLE - 1);
`ifdef RCS_SHADOW_CHECK_EN
        shadow_d = shadow_q + 1'b1;
`endif
        state_d  = S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_q == '0) state_d = S_CHECK;
        else                settle_d = settle_q - 1'b1;
      end
      S_CHECK: begin
        // Priority: shadow mismatch, then stop request, then target match.
`ifdef RCS_SHADOW_CHECK_EN
        if (cnt_q != shadow_q) begin
          err_d   = 1'b1;
          value_d = cnt_q;
          state_d = S_DONE;
        end else
`endif
        if (stop_lat_q) begin
          stopped_d = 1'b1;
          value_d   = cnt_q;
          state_d   = S_DONE;
        end else if (cnt_q == target_q) begin
          value_d = cnt_q;
          state_d = S_DONE;
        end else begin
          state_d = S_PULSE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Counter strobes are decoded from the next state and registered, so they leave a flop clean.
    pulse_d = (state_d == S_PULSE);
    clr_d   = (state_d == S_CLEAR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      target_q   <= '0;
      value_q    <= '0;
      settle_q   <= '0;
      stop_lat_q <= 1'b0;
      stopped_q  <= 1'b0;
      pulse_q    <= 1'b0;
      clr_q      <= 1'b0;
`ifdef RCS_SHADOW_CHECK_EN
      shadow_q   <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      value_q    <= value_d;
      settle_q   <= settle_d;
      stop_lat_q <= stop_lat_d;
      stopped_q  <= stopped_d;
      pulse_q    <= pulse_d;
      clr_q      <= clr_d;
`ifdef RCS_SHADOW_CHECK_EN
      shadow_q   <= shadow_d;
      err_q      <= err_d;
`endif
    end
  end

  assign cnt_pulse = pulse_q;
  assign cnt_clr   = clr_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign value     = value_q;
  assign stopped   = stopped_q;
`ifdef RCS_SHADOW_CHECK_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_ripple_count_seq.sv
// Bench for ripple_count_seq: a ripple-counter model with one cycle of ripple delay feeds cnt_q.
// Latency is counted in clock edges from the edge that accepts start to the edge that samples done=1.

module tb_ripple_count_seq;

  localparam int W = 16;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         start, stop;
  logic [W-1:0] target;
  logic [W-1:0] cnt_q_tb = '0;
  logic         cnt_pulse, cnt_clr, busy, done, stopped, err;
  logic [W-1:0] value;

  ripple_count_seq #(.W(W), .SETTLE(S)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .target    (target),
    .cnt_q     (cnt_q_tb),
    .cnt_pulse (cnt_pulse),
    .cnt_clr   (cnt_clr),
    .busy      (busy),
    .done      (done),
    .value     (value),
    .stopped   (stopped),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Ripple counter model: reacts mid-cycle, its outputs become visible one cycle later.
  logic [W-1:0] ctr = 16'hBEEF;
  int           pulse_total = 0;
  int           clr_total   = 0;
  int           pulse_base  = 0;
  bit           drop_en     = 1'b0;

  always @(negedge clk) begin
    cnt_q_tb = ctr;
    if (cnt_clr) begin
      ctr = '0;
      clr_total++;
    end else if (cnt_pulse) begin
      if (!(drop_en && (pulse_total - pulse_base) == 1)) ctr = ctr + 1'b1;
      pulse_total++;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One run: start with tgt; stop pulsed in cycle stop_at (-2: together with start, -1: never);
  // a second start with re_tgt is attempted in cycle re_at while busy.
  task automatic run(input int tgt, input int stop_at, input int re_at, input int re_tgt,
                     output int val, output bit stp, output bit er, output int lat,
                     output int pls, output int clrs, output bit to);
    int  p0, c0;
    bit  d;
    @(negedge clk);
    p0         = pulse_total;
    c0         = clr_total;
    pulse_base = p0;
    start      = 1'b1;
    target     = W'(tgt);
    stop       = (stop_at == -2);
    @(posedge clk);
    lat = 0;
    to  = 1'b1;
    for (int t = 0; t < 4000; t++) begin
      @(negedge clk);
      start = (t == re_at);
      if (t == re_at) target = W'(re_tgt);
      stop = (t == stop_at);
      d    = done;
      @(posedge clk);
      lat = t + 1;
      if (d) begin
        to = 1'b0;
        break;
      end
    end
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    val   = int'(value);
    stp   = stopped;
    er    = err;
    pls   = pulse_total - p0;
    clrs  = clr_total - c0;
    check("busy_after_done", busy, 0);
  endtask

  task automatic check_run(input string nm, input int val, input bit stp, input bit er,
                           input int lat, input int pls, input int clrs, input bit to,
                           input int e_val, input bit e_stp, input bit e_er,
                           input int e_lat, input int e_pls);
    check({nm, ".timeout"}, to, 0);
    check({nm, ".value"}, val, e_val);
    check({nm, ".stopped"}, stp, e_stp);
    check({nm, ".err"}, er, e_er);
    check({nm, ".latency"}, lat, e_lat);
    check({nm, ".pulses"}, pls, e_pls);
    check({nm, ".clears"}, clrs, 1);
  endtask

  // Reference: CHECK number j (after j pulses) sits in cycle (S+2)*(j+1)-1 after the start edge;
  // a stop held in cycle ts is seen by every CHECK in a later cycle.
  task automatic model(input int n, input int ts, output int v, output bit s,
                       output int lat, output int p);
    int tss;
    tss = (ts == -2) ? -1 : ts;
    v   = n;
    s   = 1'b0;
    lat = (S + 2) * (n + 1) + 1;
    p   = n;
    if (ts != -1) begin
      for (int j = 0; j <= n; j++) begin
        if ((S + 2) * (j + 1) - 1 > tss) begin
          v   = j;
          s   = 1'b1;
          lat = (S + 2) * (j + 1) + 1;
          p   = j;
          break;
        end
      end
    end
  endtask

  typedef struct {
    int    tgt;
    int    stop_at;
    int    exp_val;
    bit    exp_stp;
    int    exp_lat;
    int    exp_pls;
    string name;
  } vec_t;

  vec_t vecs[6];
  int   val, lat, pls, clrs, ndone, p_before;
  bit   stp, er, to;
  int   m_val, m_lat, m_pls, r_tgt, r_stop, sel;
  bit   m_stp;
  logic [W-1:0] held;

  initial begin
    vecs[0] = '{3,   -1, 3, 1'b0, 17, 3, "tgt3"};
    vecs[1] = '{0,   -1, 0, 1'b0,  5, 0, "tgt0"};
    vecs[2] = '{100,  8, 2, 1'b1, 13, 2, "stop_in_pulse2"};
    vecs[3] = '{7,   -2, 0, 1'b1,  5, 0, "stop_with_start"};
    vecs[4] = '{2,   10, 2, 1'b1, 13, 2, "stop_and_match"};
    vecs[5] = '{1,    0, 0, 1'b1,  5, 0, "stop_in_clear"};

    reset  = 1'b0;
    start  = 1'b0;
    stop   = 1'b0;
    target = '0;
    #12;
    check("reset_outputs", {busy, done, cnt_pulse, cnt_clr, stopped, err, value}, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_after_reset", {busy, done}, 0);

    for (int i = 0; i < 6; i++) begin
      run(vecs[i].tgt, vecs[i].stop_at, -1, 0, val, stp, er, lat, pls, clrs, to);
      check_run(vecs[i].name, val, stp, er, lat, pls, clrs, to,
                vecs[i].exp_val, vecs[i].exp_stp, 1'b0, vecs[i].exp_lat, vecs[i].exp_pls);
    end

    for (int k = 0; k < 25; k++) begin
      r_tgt = int'($urandom_range(0, 10));
      sel   = int'($urandom_range(0, 9));
      if (sel < 4)       r_stop = -1;
      else if (sel == 4) r_stop = -2;
      else begin
        r_stop = int'($urandom_range(0, (S + 2) * (r_tgt + 1)));
        if ((r_stop + 1) % (S + 2) == 0) r_stop = r_stop - 1;
      end
      model(r_tgt, r_stop, m_val, m_stp, m_lat, m_pls);
      run(r_tgt, r_stop, -1, 0, val, stp, er, lat, pls, clrs, to);
      check_run("random", val, stp, er, lat, pls, clrs, to, m_val, m_stp, 1'b0, m_lat, m_pls);
    end

    // Start with a new target while busy is ignored; exactly one done, value held afterwards.
    run(4, -1, 6, 9, val, stp, er, lat, pls, clrs, to);
    check_run("start_while_busy", val, stp, er, lat, pls, clrs, to, 4, 1'b0, 1'b0, 21, 4);
    ndone = 0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    check("no_second_run", ndone, 0);
    check("value_held", value, 4);

    // Stop in IDLE without start does nothing.
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      stop = 1'b1;
    end
    @(negedge clk);
    stop = 1'b0;
    check("stop_idle_no_busy", {busy, done}, 0);
    run(2, -1, -1, 0, val, stp, er, lat, pls, clrs, to);
    check_run("after_idle_stop", val, stp, er, lat, pls, clrs, to, 2, 1'b0, 1'b0, 13, 2);

    // Reset asserted mid-SETTLE.
    @(negedge clk);
    start  = 1'b1;
    target = W'(50);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_mid_run", {busy, done, cnt_pulse, cnt_clr, stopped, err, value}, 0);
    p_before = pulse_total;
    repeat (4) @(negedge clk);
    check("no_pulse_in_reset", pulse_total - p_before, 0);
    reset = 1'b1;
    @(negedge clk);
    run(1, -1, -1, 0, val, stp, er, lat, pls, clrs, to);
    check_run("after_reset", val, stp, er, lat, pls, clrs, to, 1, 1'b0, 1'b0, 9, 1);

    // Counter drops its second edge.
    drop_en = 1'b1;
    run(5, -1, -1, 0, val, stp, er, lat, pls, clrs, to);
    drop_en = 1'b0;
`ifdef RCS_SHADOW_CHECK_EN
    check_run("dropped_edge", val, stp, er, lat, pls, clrs, to, 1, 1'b0, 1'b1, 13, 2);
`else
    check_run("dropped_edge", val, stp, er, lat, pls, clrs, to, 5, 1'b0, 1'b0, 29, 6);
`endif
    held = value;
    run(3, -1, -1, 0, val, stp, er, lat, pls, clrs, to);
    check_run("err_cleared", val, stp, er, lat, pls, clrs, to, 3, 1'b0, 1'b0, 17, 3);
    check("value_changed_from_prev", (held != W'(3)), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
